// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: IFU fetch sequencer; owns the PC, issues one IMEM fetch at a time,
// follows JAL at fetch, holds on unresolved control transfers, buffers fetched words for IDU.
// Ports: clock/reset (async, active-high); io_imem_req_* fetch request (addr = PC);
// io_imem_resp_* fetched word; io_out_* FIFO head {inst, pc} to IDU with ready/valid;
// io_redirect_* backend redirect (flushes FIFO, reloads PC); io_stall high while holding.
// Optional: define IFU_PERF_EN to add io_perf_fetch_cnt / io_perf_stall_cnt counters.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h80000000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_inst,
  output logic [31:0] io_out_pc,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
`ifdef IFU_PERF_EN
  output logic        io_stall,
  output logic [31:0] io_perf_fetch_cnt,
  output logic [31:0] io_perf_stall_cnt
`else
  output logic        io_stall
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_inst [FIFO_DEPTH];
  logic [31:0]   r_ipc  [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_hs, w_push, w_pop, w_jal, w_jump;
  logic [6:0]    w_op;
  logic [2:0]    w_f3;
  logic [31:0]   w_jal_off;
  assign w_op = io_imem_resp_data[6:0];
  assign w_f3 = io_imem_resp_data[14:12];
  assign w_jal = w_op == 7'h6f;
  // JALR, conditional branches (funct3 2/3 are not branches), ECALL, EBREAK, MRET
  assign w_jump = (w_op == 7'h67 && w_f3 == 3'd0) || (w_op == 7'h63 && w_f3[2:1] != 2'b01) ||
                  io_imem_resp_data == 32'h00000073 || io_imem_resp_data == 32'h00100073 ||
                  io_imem_resp_data == 32'h30200073;
  assign w_jal_off = {{11{io_imem_resp_data[31]}}, io_imem_resp_data[31], io_imem_resp_data[19:12],
                      io_imem_resp_data[20], io_imem_resp_data[30:21], 1'b0};
  assign io_imem_req_valid = r_state == S_REQ && r_cnt < DEPTH_C;
  assign io_imem_req_addr = r_pc;
  assign w_hs = io_imem_req_valid && io_imem_req_ready;
  // a response racing a redirect belongs to the old path and is dropped
  assign w_push = r_state == S_WAIT && io_imem_resp_valid && !io_redirect_valid;
  assign w_pop = io_out_valid && io_out_ready && !io_redirect_valid;
  assign io_out_valid = r_cnt != '0;
  assign io_out_inst = r_inst[r_rd];
  assign io_out_pc = r_ipc[r_rd];
  assign io_stall = r_state == S_HOLD;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc <= RESET_PC;
    end else if (io_redirect_valid) begin
      r_pc <= io_redirect_pc;
      // a request still owed a response must have it drained in S_DROP
      r_state <= ((r_state == S_REQ && w_hs) ||
                  ((r_state == S_WAIT || r_state == S_DROP) && !io_imem_resp_valid)) ? S_DROP : S_REQ;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ:  if (w_hs) r_state <= S_WAIT;
        S_WAIT: if (io_imem_resp_valid) begin
          r_state <= w_jump ? S_HOLD : S_REQ;
          r_pc <= w_jal ? r_pc + w_jal_off : w_jump ? r_pc : r_pc + 32'd4;
        end
        S_DROP: if (io_imem_resp_valid) r_state <= S_REQ;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      r_inst <= '{default: '0};
      r_ipc <= '{default: '0};
    end else if (io_redirect_valid) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_inst[r_wr] <= io_imem_resp_data;
        r_ipc[r_wr] <= r_pc;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
`ifdef IFU_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_perf_fetch_cnt <= '0;
      io_perf_stall_cnt <= '0;
    end else begin
      io_perf_fetch_cnt <= io_perf_fetch_cnt + 32'(w_push);
      io_perf_stall_cnt <= io_perf_stall_cnt + 32'(r_state == S_HOLD);
    end
  end
`endif
endmodule
